add_seq_ctrl: RTL and testbench
===============================

# add_seq_ctrl

Multi-cycle add/subtract sequencer that computes a WIDTH-bit sum or difference by reusing one 4-bit ripple adder slice, one nibble per clock. It sits between the CPU control unit and the register datapath: it latches operands on a valid/ready request, steps through the slice LSB-first with a registered carry, and returns the result, carry-out and signed overflow on a valid/ready response. It trades latency for adder area in the phase-1 ALU.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of 4 and at least 8
- NSTEP, WIDTH/4: slice steps per operation (derived; do not override)
- clock  in  1  single clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A−B (A + ~B + 1)
- rsp_valid  out  1  result available; high only in DONE
- rsp_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- co  out  1  carry out of MSB (for sub: 1 = no borrow, i.e. A ≥ B unsigned)
- ovf  out  1  signed overflow

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready: latch a into shift register OA, (sub ? ~b : b) into OB, carry register C ← sub, step counter ← 0, go to RUN.
- RUN: slice inputs are OA[3:0], OB[3:0], C. Each cycle: C ← slice carry-out; result register shifts right by 4 with slice sum entering at [WIDTH-1:WIDTH-4]; OA, OB shift right by 4; counter increments. After step NSTEP−1, go to DONE.
- On the final step also register ovf = (carry into bit WIDTH−1) XOR (slice carry-out), where carry into MSB = OA[3]^OB[3]^slice_sum[3]; co = slice carry-out.
- DONE: rsp_valid=1; sum/co/ovf held stable. On rsp_valid&&rsp_ready go to IDLE.
- a, b, sub are sampled only at the accept edge; changes during RUN/DONE have no effect.
- req_valid in RUN/DONE is ignored (no queuing); the requester must hold it until req_ready.

## Timing
- Reset (clear high, async): state IDLE, req_ready=1, rsp_valid=0, sum=0, co=0, ovf=0, counter=0, C=0.
- clear mid-RUN or mid-DONE: operation aborted immediately, no response issued.
- Latency: accept at edge E → rsp_valid high after edge E+NSTEP (8 cycles for WIDTH=32).
- Response handshake at edge F → req_ready high after F; earliest next accept at F+1 edge. Minimum period NSTEP+2 cycles per op with rsp_ready tied high.
- rsp_ready low: DONE held indefinitely, outputs unchanged.
- sum/co/ovf remain valid after return to IDLE until the next accept overwrites them progressively; consumers use them only while rsp_valid=1.
- Slice path is combinational within one cycle; no multicycle constraints.

## Structure
- Shared package: state encoding enum (IDLE, RUN, DONE), SLICE_W=4 constant.
- One sub-module: add4_slice (4-bit ripple adder, ports a, b, ci, s, co), instantiated once. Counter width $clog2(NSTEP).

## Test plan
- 0x0000_0001 + 0xFFFF_FFFF, sub=0 → sum=0x0000_0000, co=1, ovf=0; rsp_valid rises exactly 8 cycles after accept.
- 0x7FFF_FFFF + 0x0000_0001 → sum=0x8000_0000, co=0, ovf=1.
- sub: 5 − 7 → 0xFFFF_FFFE, co=0, ovf=0; 0x8000_0000 − 1 → 0x7FFF_FFFF, co=1, ovf=1.
- rsp_ready low 5 cycles after DONE, req_valid pulsed with new operands → sum/co/ovf stable, req_ready=0, pulse ignored; after handshake req_ready=1 next cycle and next op correct.
- clear asserted at RUN step 3 → same-cycle rsp_valid=0, sum=0, state IDLE; following 0x1234_5678 + 0x1111_1111 → 0x2345_6789, co=0.
- a/b/sub toggled every cycle during RUN after accepting 0x0000_000F + 0x0000_0001 → sum=0x0000_0010, unaffected.

Source files
------------

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// the sequencer state encoding and the adder slice width.
package add_seq_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Request/response bundle between the control unit (master) and the
// add/subtract sequencer (slave).
interface add_seq_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output req_valid, a, b, sub, rsp_ready,
    input  req_ready, rsp_valid, sum, co, ovf
  );

  modport slave (
    input  req_valid, a, b, sub, rsp_ready,
    output req_ready, rsp_valid, sum, co, ovf
  );

endinterface

// File: rtl/add_seq_ctrl_add4_slice.sv
// 4-bit ripple-carry adder slice; the only adder in the sequencer, reused
// once per nibble.
module add4_slice
  import add_seq_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  always_comb begin : p_ripple
    logic c;
    // NOTE: combinational logic uses blocking '=' so the carry ripples
    // through the loop in order; every output gets a default first so no
    // latch is inferred.
    s = '0;
    c = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle add/subtract sequencer: latches operands on request, adds one
// nibble per clock LSB-first through a shared 4-bit slice, returns the result.
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32  // multiple of 4, at least 8; must match the bus
) (
  input  logic          clock,
  input  logic          clear,
  add_seq_ctrl_if.slave bus
);

  localparam int NSTEP = WIDTH / SLICE_W;
  localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  state_t             r_state;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_oa;
  logic [WIDTH-1:0]   r_ob;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_co;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_slice_s;
  logic               w_slice_co;
  logic               w_last;
  logic               w_msb_ci;

  add4_slice u_slice (
    .a  (r_oa[SLICE_W-1:0]),
    .b  (r_ob[SLICE_W-1:0]),
    .ci (r_c),
    .s  (w_slice_s),
    .co (w_slice_co)
  );

  assign w_last = (r_cnt == CNT_W'(NSTEP - 1));

  // Carry into the result MSB, recovered from the top bit of the final nibble.
  assign w_msb_ci = r_oa[SLICE_W-1] ^ r_ob[SLICE_W-1] ^ w_slice_s[SLICE_W-1];

  always_ff @(posedge clock or posedge clear) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; clear is asynchronous and aborts any operation at once.
    if (clear) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_oa        <= '0;
      r_ob        <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_co        <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_oa        <= bus.a;
            r_ob        <= bus.sub ? ~bus.b : bus.b;
            r_c         <= bus.sub;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_c   <= w_slice_co;
          r_sum <= {w_slice_s, r_sum[WIDTH-1:SLICE_W]};
          r_oa  <= r_oa >> SLICE_W;
          r_ob  <= r_ob >> SLICE_W;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_co        <= w_slice_co;
            r_ovf       <= w_msb_ci ^ w_slice_co;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.sum       = r_sum;
  assign bus.co        = r_co;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: table vectors, random ops against an
// arithmetic model, and hand sequences for backpressure, abort and input hold.
module tb_add_seq_ctrl;

  localparam int WIDTH = 32;
  localparam int NSTEP = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
  } rsp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    rsp_t             exp;
  } vec_t;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  add_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  add_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  rsp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic rsp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic o);
    rsp_t r;
    r.sum = s;
    r.co  = c;
    r.ovf = o;
    return r;
  endfunction

  // Reference arithmetic: full-width add of A and (B or ~B) plus carry-in.
  function automatic rsp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   t;
    rsp_t             r;
    bb    = sub ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub);
    r.sum = t[WIDTH-1:0];
    r.co  = t[WIDTH];
    r.ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request, wait for acceptance, optionally record the expected result.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                      input rsp_t exp, input bit expect_rsp, input string tag);
    int n;
    bus.a         = a;
    bus.b         = b;
    bus.sub       = sub;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 4 * NSTEP) begin
      tick();
      n++;
    end
    if (!bus.req_ready) begin
      fail_now({tag, "_accept"});
      bus.req_valid = 1'b0;
      return;
    end
    tick();
    bus.req_valid = 1'b0;
    if (expect_rsp) sb_q.push_back(exp);
  endtask

  // Count cycles from the accept edge until rsp_valid; optionally scramble inputs.
  task automatic wait_rsp(output int lat, output bit ok, input bit scramble, input string tag);
    lat = 0;
    while (!bus.rsp_valid && lat < 4 * NSTEP) begin
      if (scramble) begin
        bus.a   = $urandom;
        bus.b   = $urandom;
        bus.sub = ~bus.sub;
      end
      tick();
      lat++;
    end
    ok = bus.rsp_valid;
    if (!ok) fail_now({tag, "_rsp"});
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_scoreboard: response with no expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_sum"}, bus.sum, e.sum);
    check({tag, "_co"},  bus.co,  e.co);
    check({tag, "_ovf"}, bus.ovf, e.ovf);
  endtask

  // Full op with rsp_ready high: accept, latency, result, handshake.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                        input rsp_t exp, input string tag);
    int lat;
    bit ok;
    send(a, b, sub, exp, 1'b1, tag);
    wait_rsp(lat, ok, 1'b0, tag);
    if (ok) begin
      check({tag, "_latency"}, lat, NSTEP);
      check_rsp(tag);
      tick();
      check({tag, "_req_ready_after_hs"}, bus.req_ready, 1'b1);
      check({tag, "_rsp_valid_after_hs"}, bus.rsp_valid, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   lat;
    bit   ok;
    logic [WIDTH-1:0] ra, rb;
    logic             rs;

    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0)};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1)};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0)};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1)};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0)};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, mk(32'hFFFF_FFFE, 1'b1, 1'b0)};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0)};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, mk(32'h0000_0000, 1'b1, 1'b1)};
    vecs[8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1)};
    vecs[9] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, mk(32'hFFFF_FFFF, 1'b0, 1'b0)};

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    clear         = 1'b1;

    #3;
    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_sum",       bus.sum,       32'h0);
    check("reset_co",        bus.co,        1'b0);
    check("reset_ovf",       bus.ovf,       1'b0);
    #4;
    clear = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, model(ra, rb, rs), $sformatf("rnd%0d", i));
    end

    // Backpressure: DONE held with rsp_ready low while new requests are offered.
    bus.rsp_ready = 1'b0;
    send(32'h0000_0010, 32'h0000_0020, 1'b0, mk(32'h0000_0030, 1'b0, 1'b0), 1'b1, "bp");
    wait_rsp(lat, ok, 1'b0, "bp");
    if (ok) begin
      check("bp_latency", lat, NSTEP);
      for (int k = 0; k < 5; k++) begin
        bus.req_valid = 1'b1;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.sub       = k[0];
        tick();
        bus.req_valid = 1'b0;
        check($sformatf("bp_hold%0d_sum", k),       bus.sum,       32'h0000_0030);
        check($sformatf("bp_hold%0d_co", k),        bus.co,        1'b0);
        check($sformatf("bp_hold%0d_ovf", k),       bus.ovf,       1'b0);
        check($sformatf("bp_hold%0d_rsp_valid", k), bus.rsp_valid, 1'b1);
        check($sformatf("bp_hold%0d_req_ready", k), bus.req_ready, 1'b0);
      end
      check_rsp("bp");
      bus.rsp_ready = 1'b1;
      tick();
      check("bp_req_ready_after_hs", bus.req_ready, 1'b1);
      check("bp_rsp_valid_after_hs", bus.rsp_valid, 1'b0);
    end
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1), "bp_next");

    // Abort: clear asserted while the fourth slice step is in progress.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0, 1'b1, 1'b0), 1'b0, "abort");
    for (int k = 0; k < 3; k++) tick();
    clear = 1'b1;
    #1;
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check("abort_req_ready", bus.req_ready, 1'b1);
    check("abort_sum",       bus.sum,       32'h0);
    check("abort_co",        bus.co,        1'b0);
    check("abort_ovf",       bus.ovf,       1'b0);
    clear = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < NSTEP + 2; k++) begin
        tick();
        if (bus.rsp_valid) seen++;
      end
      check("abort_no_response", seen, 0);
    end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0), "after_abort");

    // Operand hold: inputs scrambled every cycle while the op is running.
    send(32'h0000_000F, 32'h0000_0001, 1'b0, mk(32'h0000_0010, 1'b0, 1'b0), 1'b1, "scramble");
    wait_rsp(lat, ok, 1'b1, "scramble");
    if (ok) begin
      check("scramble_latency", lat, NSTEP);
      check_rsp("scramble");
      tick();
      check("scramble_req_ready_after_hs", bus.req_ready, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
